// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and widths for the SRAM access arbiter.
//   sram_req_id_t : identifies which requester owns an SRAM access / read tag
//   SRAM_ADDR_W   : SRAM word address width
//   SRAM_DATA_W   : SRAM data width
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VGA,
    REQ_UART,
    REQ_DEC
  } sram_req_id_t;

  // Number of asserted request lines (0..3).
  function automatic logic [1:0] count_pending(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/sram_read_tag_pipe.sv
// ---------------------------------------------------------------------------
// sram_read_tag_pipe
// DEPTH-stage shift register of requester tags. The tag pushed in the cycle
// an SRAM read address is issued emerges DEPTH clocks later, aligned with
// the SRAM read data it belongs to.
//   clk    in  clock
//   rst_n  in  asynchronous active-low clear (all stages to REQ_NONE)
//   tag_i  in  tag of the access issued this cycle (REQ_NONE for writes/idle)
//   tag_o  out tag of the read whose data is on SRAM_read_data now
// ---------------------------------------------------------------------------
module sram_read_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  sram_req_id_t tag_i,
  output sram_req_id_t tag_o
);

  sram_req_id_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= REQ_NONE;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
// Shares one SRAM_controller port between the VGA reader, the UART writer
// and the decompressor. Grants are combinational (same cycle as request),
// one access per cycle, no bubbles. Read data is routed back by a tag that
// travels alongside the SRAM read latency.
//   Clock / Resetn          : clock, async active-low reset
//   uart_excl               : only UART may be granted while high
//   vga_req/addr, vga_gnt   : VGA read port; vga_rvalid qualifies rdata
//   uart_req/addr/wdata/we_n, uart_gnt : UART port (reads return no rvalid)
//   dec_req/addr/wdata/we_n, dec_gnt   : DEC port; dec_rvalid qualifies rdata
//   rdata                   : registered copy of SRAM_read_data
//   SRAM_address/write_data/we_n, SRAM_read_data : controller interface
//   conflict_count          : saturating count of multi-request cycles
// ---------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   uart_excl,
  input  logic                   vga_req,
  input  logic [SRAM_ADDR_W-1:0] vga_addr,
  output logic                   vga_gnt,
  output logic                   vga_rvalid,
  input  logic                   uart_req,
  input  logic [SRAM_ADDR_W-1:0] uart_addr,
  input  logic [SRAM_DATA_W-1:0] uart_wdata,
  input  logic                   uart_we_n,
  output logic                   uart_gnt,
  input  logic                   dec_req,
  input  logic [SRAM_ADDR_W-1:0] dec_addr,
  input  logic [SRAM_DATA_W-1:0] dec_wdata,
  input  logic                   dec_we_n,
  output logic                   dec_gnt,
  output logic                   dec_rvalid,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic [SRAM_ADDR_W-1:0] SRAM_address,
  output logic [SRAM_DATA_W-1:0] SRAM_write_data,
  output logic                   SRAM_we_n,
  input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
  output logic [15:0]            conflict_count
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  sram_req_id_t          winner;
  sram_req_id_t          push_tag;
  sram_req_id_t          out_tag;
  sram_req_id_t          rr_last_q, rr_last_d;
  logic [STARVE_W-1:0]   uart_starve_q, uart_starve_d;
  logic [STARVE_W-1:0]   dec_starve_q, dec_starve_d;
  logic [15:0]           conflict_q, conflict_d;
  logic                  vga_rvalid_q, dec_rvalid_q;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic                  uart_starved, dec_starved;
  logic [1:0]            pending;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    winner       = REQ_NONE;
    uart_starved = uart_req && (uart_starve_q == STARVE_MAX);
    dec_starved  = dec_req && (dec_starve_q == STARVE_MAX);
    if (!Resetn) begin
      winner = REQ_NONE;
    end else if (uart_excl) begin
      winner = uart_req ? REQ_UART : REQ_NONE;
    end else if (uart_starved && dec_starved) begin
      // Both starved: fall back to round-robin order between them.
      winner = (rr_last_q == REQ_UART) ? REQ_DEC : REQ_UART;
    end else if (uart_starved) begin
      winner = REQ_UART;
    end else if (dec_starved) begin
      winner = REQ_DEC;
    end else if (vga_req) begin
      winner = REQ_VGA;
    end else if (uart_req && dec_req) begin
      winner = (rr_last_q == REQ_UART) ? REQ_DEC : REQ_UART;
    end else if (uart_req) begin
      winner = REQ_UART;
    end else if (dec_req) begin
      winner = REQ_DEC;
    end
  end

  assign vga_gnt  = (winner == REQ_VGA);
  assign uart_gnt = (winner == REQ_UART);
  assign dec_gnt  = (winner == REQ_DEC);

  // -------------------------------------------------------------------------
  // SRAM port mux (VGA is read-only, so it never drives write data)
  // -------------------------------------------------------------------------
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (winner)
      REQ_VGA: begin
        SRAM_address = vga_addr;
      end
      REQ_UART: begin
        SRAM_address    = uart_addr;
        SRAM_write_data = uart_wdata;
        SRAM_we_n       = uart_we_n;
      end
      REQ_DEC: begin
        SRAM_address    = dec_addr;
        SRAM_write_data = dec_wdata;
        SRAM_we_n       = dec_we_n;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Arbitration state next-state
  // -------------------------------------------------------------------------
  always_comb begin
    rr_last_d = rr_last_q;
    if (winner == REQ_UART || winner == REQ_DEC) begin
      rr_last_d = winner;
    end

    // Counters freeze (rather than clear) while uart_excl holds requests off.
    uart_starve_d = uart_starve_q;
    if (!uart_req || uart_gnt) begin
      uart_starve_d = '0;
    end else if (!uart_excl && uart_starve_q != STARVE_MAX) begin
      uart_starve_d = uart_starve_q + 1'b1;
    end

    dec_starve_d = dec_starve_q;
    if (!dec_req || dec_gnt) begin
      dec_starve_d = '0;
    end else if (!uart_excl && dec_starve_q != STARVE_MAX) begin
      dec_starve_d = dec_starve_q + 1'b1;
    end

    // Only requests that could actually be granted count as contending.
    pending    = count_pending(vga_req && !uart_excl, uart_req, dec_req && !uart_excl);
    conflict_d = conflict_q;
    if (pending >= 2'd2 && conflict_q != 16'hFFFF) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Read tagging and data return
  // -------------------------------------------------------------------------
  assign push_tag = (winner != REQ_NONE && SRAM_we_n) ? winner : REQ_NONE;

  sram_read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk   (Clock),
    .rst_n (Resetn),
    .tag_i (push_tag),
    .tag_o (out_tag)
  );

  assign rdata_d = (out_tag != REQ_NONE) ? SRAM_read_data : rdata_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rr_last_q     <= REQ_DEC;
      uart_starve_q <= '0;
      dec_starve_q  <= '0;
      conflict_q    <= '0;
      vga_rvalid_q  <= 1'b0;
      dec_rvalid_q  <= 1'b0;
      rdata_q       <= '0;
    end else begin
      rr_last_q     <= rr_last_d;
      uart_starve_q <= uart_starve_d;
      dec_starve_q  <= dec_starve_d;
      conflict_q    <= conflict_d;
      vga_rvalid_q  <= (out_tag == REQ_VGA);
      dec_rvalid_q  <= (out_tag == REQ_DEC);
      rdata_q       <= rdata_d;
    end
  end

  assign vga_rvalid     = vga_rvalid_q;
  assign dec_rvalid     = dec_rvalid_q;
  assign rdata          = rdata_q;
  assign conflict_count = conflict_q;

endmodule
